fixed_predictor_decoder: RTL and testbench

//  Downstream consumer of the residual decoder. Rebuilds PCM samples for one FLAC

---
 rtl/fixed_pred_pkg.sv | 29 ++
 rtl/fixed_pred_calc.sv | 61 ++++++
 rtl/fixed_predictor_decoder.sv | 158 +++++++++++++++
 tb/tb_fixed_predictor_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pred_pkg.sv
// Shared definitions for the FLAC FIXED-subframe reconstruction path:
// FSM encoding, accumulator sizing and the fixed-polynomial coefficient table.
package fixed_pred_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_DECODE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int MAX_ORDER = 4;

    // |prediction + residual| <= 16 * 2^(SAMPLE_W-1), so four guard bits suffice.
    localparam int ACC_GUARD = 4;

    function automatic int acc_width(input int sample_w);
        return sample_w + ACC_GUARD;
    endfunction

    // Row = order, column = history tap (s1 newest); unused taps are zero.
    localparam int COEF [1:MAX_ORDER][1:MAX_ORDER] = '{
        '{ 1,  0, 0,  0},
        '{ 2, -1, 0,  0},
        '{ 3, -3, 1,  0},
        '{ 4, -6, 4, -1}
    };

endpackage

// File: rtl/fixed_pred_calc.sv
// Combinational fixed-polynomial predictor: order x sample history -> ACC_W
// prediction, built from shifts and adds only.
module fixed_pred_calc
    import fixed_pred_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = SAMPLE_W + ACC_GUARD
) (
    input  logic [2:0]            order,
    input  logic [4*SAMPLE_W-1:0] history,
    output logic [ACC_W-1:0]      pred
);

    // Every coefficient in the table is a constant, so each call folds to
    // one or two shifted copies of the operand.
    function automatic logic signed [ACC_W-1:0] scale(
        input logic signed [ACC_W-1:0] x,
        input int                      c
    );
        case (c)
            1:       scale = x;
            2:       scale = x <<< 1;
            3:       scale = (x <<< 1) + x;
            4:       scale = x <<< 2;
            -1:      scale = -x;
            -3:      scale = -((x <<< 1) + x);
            -6:      scale = -((x <<< 2) + (x <<< 1));
            default: scale = '0;
        endcase
    endfunction

    logic signed [ACC_W-1:0] ext    [1:MAX_ORDER];
    logic signed [ACC_W-1:0] term   [1:MAX_ORDER][1:MAX_ORDER];
    logic signed [ACC_W-1:0] by_ord [1:MAX_ORDER];

    genvar gi, gj;
    generate
        for (gi = 1; gi <= MAX_ORDER; gi++) begin : g_ext
            assign ext[gi] = {{(ACC_W-SAMPLE_W){history[gi*SAMPLE_W-1]}},
                              history[gi*SAMPLE_W-1 -: SAMPLE_W]};
        end
        for (gi = 1; gi <= MAX_ORDER; gi++) begin : g_ord
            for (gj = 1; gj <= MAX_ORDER; gj++) begin : g_tap
                assign term[gi][gj] = scale(ext[gj], COEF[gi][gj]);
            end
            assign by_ord[gi] = term[gi][1] + term[gi][2] + term[gi][3] + term[gi][4];
        end
    endgenerate

    always_comb begin
        pred = '0;
        case (order)
            3'd1:    pred = by_ord[1];
            3'd2:    pred = by_ord[2];
            3'd3:    pred = by_ord[3];
            3'd4:    pred = by_ord[4];
            default: pred = '0;
        endcase
    end

endmodule

// File: rtl/fixed_predictor_decoder.sv
// FLAC FIXED subframe sample reconstruction (orders 0-4): warm-up pass-through,
// then residual + polynomial prediction. Define FIXED_PRED_SAT_EN to saturate instead of wrap.
module fixed_predictor_decoder
    import fixed_pred_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = SAMPLE_W + ACC_GUARD
) (
    input  logic                iClock,
    input  logic                iReset_n,
    input  logic                iStart,
    input  logic [2:0]          iOrder,
    input  logic [15:0]         iBlockSize,
    input  logic                iValid,
    input  logic [SAMPLE_W-1:0] iData,
    output logic [SAMPLE_W-1:0] oSample,
    output logic                oValid,
    output logic                oDone,
    output logic                oError
);

    state_t                state_reg, state_next;
    logic [2:0]            order_reg;
    logic [15:0]           bsize_reg;
    logic [15:0]           count_reg;
    logic [15:0]           count_inc;
    logic [4*SAMPLE_W-1:0] hist_reg;
    logic [SAMPLE_W-1:0]   sample_reg;
    logic                  valid_reg;
    logic                  done_reg;
    logic                  error_reg;

    logic [ACC_W-1:0]        pred;
    logic signed [ACC_W-1:0] sum;
    logic [SAMPLE_W-1:0]     recon;
    logic                    order_ok;

    fixed_pred_calc #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_W)
    ) u_calc (
        .order   (order_reg),
        .history (hist_reg),
        .pred    (pred)
    );

    assign count_inc = count_reg + 16'd1;
    assign order_ok  = (iOrder <= 3'(MAX_ORDER));
    assign sum       = $signed(pred)
                     + $signed({{(ACC_W-SAMPLE_W){iData[SAMPLE_W-1]}}, iData});

`ifdef FIXED_PRED_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    always_comb begin
        recon = sum[SAMPLE_W-1:0];
        if (sum > SAT_MAX)
            recon = SAT_MAX[SAMPLE_W-1:0];
        else if (sum < SAT_MIN)
            recon = SAT_MIN[SAMPLE_W-1:0];
    end
`else
    logic sum_unused;
    assign recon      = sum[SAMPLE_W-1:0];
    assign sum_unused = ^sum[ACC_W-1:SAMPLE_W];
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (iStart && order_ok) begin
                    if (iBlockSize == 16'd0)
                        state_next = ST_DONE;
                    else if (iOrder != 3'd0)
                        state_next = ST_WARMUP;
                    else
                        state_next = ST_DECODE;
                end
            end
            ST_WARMUP: begin
                // A short block can end before the warm-ups do.
                if (iValid) begin
                    if (count_inc == bsize_reg)
                        state_next = ST_DONE;
                    else if (count_inc == {13'd0, order_reg})
                        state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (iValid && count_inc == bsize_reg)
                    state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            state_reg  <= ST_IDLE;
            order_reg  <= '0;
            bsize_reg  <= '0;
            count_reg  <= '0;
            hist_reg   <= '0;
            sample_reg <= '0;
            valid_reg  <= 1'b0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= 1'b0;
            // Delayed by one so the pulse never overlaps the final sample strobe.
            done_reg  <= (state_reg == ST_DONE);
            case (state_reg)
                ST_IDLE: begin
                    if (iStart) begin
                        if (!order_ok) begin
                            error_reg <= 1'b1;
                        end else begin
                            error_reg <= 1'b0;
                            order_reg <= iOrder;
                            bsize_reg <= iBlockSize;
                            count_reg <= '0;
                            hist_reg  <= '0;
                        end
                    end
                end
                ST_WARMUP: begin
                    if (iValid) begin
                        sample_reg <= iData;
                        valid_reg  <= 1'b1;
                        hist_reg   <= {hist_reg[3*SAMPLE_W-1:0], iData};
                        count_reg  <= count_inc;
                    end
                end
                ST_DECODE: begin
                    if (iValid) begin
                        sample_reg <= recon;
                        valid_reg  <= 1'b1;
                        hist_reg   <= {hist_reg[3*SAMPLE_W-1:0], recon};
                        count_reg  <= count_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oSample = sample_reg;
    assign oValid  = valid_reg;
    assign oDone   = done_reg;
    assign oError  = error_reg;

endmodule

// File: tb/tb_fixed_predictor_decoder.sv
// Self-checking bench for fixed_predictor_decoder: vector table plus randomised
// frames against a reference predictor; honours FIXED_PRED_SAT_EN.
module tb_fixed_predictor_decoder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   order;
    logic [15:0]  bsize;
    logic         valid_in;
    logic [W-1:0] data_in;
    logic [W-1:0] sample_out;
    logic         valid_out;
    logic         done_out;
    logic         error_out;

    fixed_predictor_decoder #(.SAMPLE_W(W)) dut (
        .iClock     (clk),
        .iReset_n   (rst_n),
        .iStart     (start),
        .iOrder     (order),
        .iBlockSize (bsize),
        .iValid     (valid_in),
        .iData      (data_in),
        .oSample    (sample_out),
        .oValid     (valid_out),
        .oDone      (done_out),
        .oError     (error_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ord;
        int bs;
        int n;
        int din  [8];
        int dexp [8];
    } vec_t;

    vec_t vecs [7];
    int   exp_q [$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;
    int   done_cyc = 0;
    int   done_seen = 0;
    int   frame_id = 0;

    function automatic int narrow(input int v);
`ifdef FIXED_PRED_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        logic [15:0] v16;
        v16 = v[15:0];
        return int'($signed(v16));
`endif
    endfunction

    function automatic int ref_pred(input int o, input int h0, input int h1,
                                    input int h2, input int h3);
        case (o)
            1:       return h0;
            2:       return 2*h0 - h1;
            3:       return 3*h0 - 3*h1 + h2;
            4:       return 4*h0 - 6*h1 + 4*h2 - h3;
            default: return 0;
        endcase
    endfunction

    task automatic expect_eq(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got=%0d required=%0d", name, got, req);
        end
    endtask

    // Scoreboard side: sampled 1 time unit after each rising edge.
    task automatic check_outputs();
        int got;
        if (valid_out) begin
            last_valid_cyc = cyc;
            got = int'($signed(sample_out));
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid cyc=%0d got=%0d required=no_output", cyc, got);
            end else begin
                expect_eq($sformatf("sample frame%0d", frame_id), got, exp_q.pop_front());
            end
        end
        if (done_out) begin
            done_seen++;
            done_cyc = cyc;
            expect_eq("done_not_with_valid", int'(valid_out), 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic run_frame(input int o, input int bs, input int n,
                             input int din[16], input int dexp[16], input int gmax);
        int d0;
        frame_id++;
        start = 1'b1;
        order = 3'(o);
        bsize = 16'(bs);
        tick();
        start = 1'b0;
        d0 = done_seen;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gmax)) tick();
            valid_in = 1'b1;
            data_in  = W'(din[i]);
            exp_q.push_back(dexp[i]);
            tick();
            valid_in = 1'b0;
        end
        for (int k = 0; k < 20 && done_seen == d0; k++) tick();
        expect_eq($sformatf("done_count frame%0d", frame_id), done_seen - d0, 1);
        expect_eq($sformatf("pending frame%0d", frame_id), exp_q.size(), 0);
        if (n > 0)
            expect_eq($sformatf("done_delay frame%0d", frame_id), done_cyc - last_valid_cyc, 1);
    endtask

    task automatic model_frame(input int o, input int bs, input int gmax);
        int din[16];
        int dexp[16];
        int h0, h1, h2, h3, e;
        h0 = 0; h1 = 0; h2 = 0; h3 = 0;
        for (int i = 0; i < 16; i++) begin
            din[i] = 0;
            dexp[i] = 0;
        end
        for (int i = 0; i < bs; i++) begin
            if (i < o) begin
                din[i] = int'($urandom_range(0, 2000)) - 1000;
                e = din[i];
            end else begin
                din[i] = int'($urandom_range(0, 400)) - 200;
                e = narrow(ref_pred(o, h0, h1, h2, h3) + din[i]);
            end
            dexp[i] = e;
            h3 = h2; h2 = h1; h1 = h0; h0 = e;
        end
        run_frame(o, bs, bs, din, dexp, gmax);
    endtask

    initial begin
        int din[16];
        int dexp[16];

        vecs[0] = '{ord: 2, bs: 5, n: 5, din: '{10, 12, 1, 0, -1, 0, 0, 0},
                    dexp: '{10, 12, 15, 18, 20, 0, 0, 0}};
        vecs[1] = '{ord: 4, bs: 6, n: 6, din: '{1, 2, 3, 4, 0, 0, 0, 0},
                    dexp: '{1, 2, 3, 4, 5, 6, 0, 0}};
        vecs[2] = '{ord: 0, bs: 3, n: 3, din: '{7, -7, 0, 0, 0, 0, 0, 0},
                    dexp: '{7, -7, 0, 0, 0, 0, 0, 0}};
        vecs[3] = '{ord: 3, bs: 2, n: 2, din: '{5, -3, 0, 0, 0, 0, 0, 0},
                    dexp: '{5, -3, 0, 0, 0, 0, 0, 0}};
`ifdef FIXED_PRED_SAT_EN
        vecs[4] = '{ord: 1, bs: 3, n: 3, din: '{32767, 1, 0, 0, 0, 0, 0, 0},
                    dexp: '{32767, 32767, 32767, 0, 0, 0, 0, 0}};
`else
        vecs[4] = '{ord: 1, bs: 3, n: 3, din: '{32767, 1, 0, 0, 0, 0, 0, 0},
                    dexp: '{32767, -32768, -32768, 0, 0, 0, 0, 0}};
`endif
        vecs[5] = '{ord: 0, bs: 0, n: 0, din: '{0, 0, 0, 0, 0, 0, 0, 0},
                    dexp: '{0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[6] = '{ord: 1, bs: 4, n: 4, din: '{-5, 3, -2, 10, 0, 0, 0, 0},
                    dexp: '{-5, -2, -4, 6, 0, 0, 0, 0}};

        rst_n    = 1'b0;
        start    = 1'b0;
        order    = '0;
        bsize    = '0;
        valid_in = 1'b0;
        data_in  = '0;
        repeat (3) tick();
        expect_eq("reset_sample", int'(sample_out), 0);
        expect_eq("reset_valid", int'(valid_out), 0);
        expect_eq("reset_done", int'(done_out), 0);
        expect_eq("reset_error", int'(error_out), 0);
        rst_n = 1'b1;
        tick();

        // Data offered while idle must be ignored.
        valid_in = 1'b1;
        data_in  = 16'd99;
        repeat (3) tick();
        valid_in = 1'b0;

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 16; i++) begin
                din[i]  = (i < 8) ? vecs[v].din[i] : 0;
                dexp[i] = (i < 8) ? vecs[v].dexp[i] : 0;
            end
            run_frame(vecs[v].ord, vecs[v].bs, vecs[v].n, din, dexp, (v == 6) ? 3 : 0);
        end

        // Illegal order: sticky error, nothing emitted, then cleared by a good start.
        start = 1'b1;
        order = 3'd5;
        bsize = 16'd4;
        tick();
        start = 1'b0;
        expect_eq("error_set", int'(error_out), 1);
        valid_in = 1'b1;
        repeat (4) tick();
        valid_in = 1'b0;
        expect_eq("error_sticky", int'(error_out), 1);
        expect_eq("error_no_done", int'(done_out), 0);
        model_frame(2, 4, 0);
        expect_eq("error_cleared", int'(error_out), 0);

        // Reset clears a pending error while idle.
        start = 1'b1;
        order = 3'd7;
        tick();
        start = 1'b0;
        expect_eq("error_set2", int'(error_out), 1);
        rst_n = 1'b0;
        tick();
        expect_eq("error_reset", int'(error_out), 0);
        rst_n = 1'b1;
        tick();

        // Abort mid-decode; a stray iStart inside the frame must not restart it.
        frame_id++;
        start = 1'b1;
        order = 3'd2;
        bsize = 16'd10;
        tick();
        start = 1'b0;
        begin
            int h0, h1, e;
            int seq[4];
            seq[0] = 100; seq[1] = 110; seq[2] = 3; seq[3] = -4;
            h0 = 0; h1 = 0;
            for (int i = 0; i < 4; i++) begin
                e = (i < 2) ? seq[i] : narrow(2*h0 - h1 + seq[i]);
                h1 = h0; h0 = e;
                valid_in = 1'b1;
                data_in  = W'(seq[i]);
                start    = (i == 2);
                order    = 3'd0;
                bsize    = 16'd1;
                exp_q.push_back(e);
                tick();
                start    = 1'b0;
                valid_in = 1'b0;
            end
        end
        rst_n    = 1'b0;
        valid_in = 1'b1;
        data_in  = 16'd123;
        tick();
        expect_eq("abort_sample", int'(sample_out), 0);
        expect_eq("abort_valid", int'(valid_out), 0);
        expect_eq("abort_done", int'(done_out), 0);
        expect_eq("abort_pending", exp_q.size(), 0);
        rst_n    = 1'b1;
        valid_in = 1'b0;
        tick();

        // Randomised frames with iValid gaps, checked against the reference predictor.
        model_frame(3, 12, 0);
        for (int r = 0; r < 10; r++)
            model_frame(int'($urandom_range(0, 4)), int'($urandom_range(1, 16)), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
